// File: rtl/readout_pkg.sv
// Shared types and constants for the multi-channel serial readout.
// State encoding, counter widths and a constant clog2 helper.
package readout_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XMIT = 2'd1,
    PUSH = 2'd2
  } state_e;

  localparam int SEQ_W = 8;
  localparam int OVF_W = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((32'sd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/readout_multi_if.sv
// Host-side pipe bundle: FIFO read strobe, head word, flags, status.
// The readout drives the slave side; the host drives fiforead.
interface readout_multi_if
  import readout_pkg::*;
#(
  parameter int WORD_W = 64,
  parameter int LVL_W  = 7
);

  logic              fiforead;
  logic [WORD_W-1:0] data2pipe;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_flag;
  logic [LVL_W-1:0]  fifo_level;
  logic [OVF_W-1:0]  overflow_cnt;
  logic [1:0]        state;
  logic              done;

  modport slave (
    input  fiforead,
    output data2pipe,
    output fifo_empty,
    output fifo_full,
    output fifo_flag,
    output fifo_level,
    output overflow_cnt,
    output state,
    output done
  );

  modport master (
    output fiforead,
    input  data2pipe,
    input  fifo_empty,
    input  fifo_full,
    input  fifo_flag,
    input  fifo_level,
    input  overflow_cnt,
    input  state,
    input  done
  );

endinterface

// File: rtl/readout_fifo.sv
// Synchronous first-word-fall-through FIFO with registered head and flags.
// A push while full is accepted only when a pop frees the slot that cycle.
module readout_fifo
  import readout_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 64,
  parameter int WMARK = 32,
  localparam int AW = clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             wmark,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             empty_q, full_q, wmark_q;
  logic             do_wr, do_rd;

  assign do_rd  = rd_en & ~empty_q;
  assign do_wr  = wr_en & (~full_q | rd_en);
  assign rd_nxt = rd_ptr_q + 1'b1;

  always_comb begin
    level_d = level_q;
    dout_d  = dout_q;
    case ({do_wr, do_rd})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    // Head register refills from the next slot, or from din when that is the only word.
    if (do_rd) begin
      if (level_q > LW'(1)) dout_d = mem[rd_nxt];
      else if (do_wr)       dout_d = din;
    end else if (do_wr && empty_q) begin
      dout_d = din;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dout_q   <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      wmark_q  <= 1'b0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_nxt;
      level_q <= level_d;
      dout_q  <= dout_d;
      empty_q <= (level_d == '0);
      full_q  <= (level_d == LW'(DEPTH));
      wmark_q <= (level_d >= LW'(WMARK));
    end
  end

  assign dout  = dout_q;
  assign empty = empty_q;
  assign full  = full_q;
  assign wmark = wmark_q;
  assign level = level_q;

endmodule

// File: rtl/readout_multi.sv
// Multi-channel serial readout: frames DOUT bits into tagged words
// and buffers them for the host in a FWFT FIFO.
module readout_multi
  import readout_pkg::*;
#(
  parameter int CH_NUM      = 2,
  parameter int BITS_PER_CH = 20,
  parameter int MSB_FIRST   = 0,
  parameter int WORD_W      = 64,
  parameter int FIFO_DEPTH  = 64,
  parameter int WATERMARK   = 32
) (
  input  logic           SYS_CLK,
  input  logic           RST,
  input  logic           DVALID_BAR,
  input  logic           DOUT,
  output logic           DXMIT_BAR,
  readout_multi_if.slave host
);

  localparam int FB = CH_NUM * BITS_PER_CH;
  localparam int CW = clog2(FB + 1);
  localparam int LW = clog2(FIFO_DEPTH) + 1;

  logic             dv_s1_q, dv_s2_q, dv_prev_q, fall;
  state_e           state_q, state_d;
  logic             dxmit_q, dxmit_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [FB-1:0]    sr_q, sr_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [OVF_W-1:0] ovf_q, ovf_d;
  logic             push, done;
  logic [FB-1:0]    frame;
  logic [WORD_W-1:0] word;
  logic             f_full, f_empty, f_flag;
  logic [LW-1:0]    f_level;

  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      dv_s1_q   <= 1'b1;
      dv_s2_q   <= 1'b1;
      dv_prev_q <= 1'b1;
    end else begin
      dv_s1_q   <= DVALID_BAR;
      dv_s2_q   <= dv_s1_q;
      dv_prev_q <= dv_s2_q;
    end
  end

  assign fall = ~dv_s2_q & dv_prev_q;

  // Bits shift in at the top, so frame bit k sits at sr[k] after FB shifts.
  always_comb begin
    frame = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      for (int j = 0; j < BITS_PER_CH; j++) begin
        if (MSB_FIRST != 0)
          frame[c*BITS_PER_CH+j] = sr_q[c*BITS_PER_CH+BITS_PER_CH-1-j];
        else
          frame[c*BITS_PER_CH+j] = sr_q[c*BITS_PER_CH+j];
      end
    end
    word = '0;
    word[FB-1:0] = frame;
    word[WORD_W-1 -: SEQ_W] = seq_q;
  end

  always_comb begin
    state_d = state_q;
    dxmit_d = dxmit_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    seq_d   = seq_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = XMIT;
          dxmit_d = 1'b0;
        end
      end
      XMIT: begin
        sr_d  = {DOUT, sr_q[FB-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(FB - 1)) begin
          state_d = PUSH;
          dxmit_d = 1'b1;
        end
      end
      PUSH: begin
        done    = 1'b1;
        push    = 1'b1;
        seq_d   = seq_q + 1'b1;
        state_d = IDLE;
        if (f_full && !host.fiforead && ovf_q != '1)
          ovf_d = ovf_q + 1'b1;
      end
      default: begin
        state_d = IDLE;
        dxmit_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      dxmit_q <= 1'b1;
      cnt_q   <= '0;
      sr_q    <= '0;
      seq_q   <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      dxmit_q <= dxmit_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      seq_q   <= seq_d;
      ovf_q   <= ovf_d;
    end
  end

  readout_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH),
    .WMARK (WATERMARK)
  ) u_fifo (
    .clk   (SYS_CLK),
    .rst   (RST),
    .wr_en (push),
    .din   (word),
    .rd_en (host.fiforead),
    .dout  (host.data2pipe),
    .empty (f_empty),
    .full  (f_full),
    .wmark (f_flag),
    .level (f_level)
  );

  assign DXMIT_BAR         = dxmit_q;
  assign host.fifo_empty   = f_empty;
  assign host.fifo_full    = f_full;
  assign host.fifo_flag    = f_flag;
  assign host.fifo_level   = f_level;
  assign host.overflow_cnt = ovf_q;
  assign host.state        = state_q;
  assign host.done         = done;

endmodule

// File: tb/tb_readout_multi.sv
// Directed bench for readout_multi: framing, bit order, FIFO fill/overflow,
// pop-at-full, ignored mid-frame edges and reset mid-frame.
module tb_readout_multi;

  logic clk = 1'b0;
  logic rst;
  logic dv0, do0, dx0;
  logic dv1, do1, dx1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt0 = 0;

  always #5 clk = ~clk;

  readout_multi_if #(.WORD_W(64), .LVL_W(7)) bus0 ();
  readout_multi_if #(.WORD_W(64), .LVL_W(7)) bus1 ();

  readout_multi #(.MSB_FIRST(0)) dut0 (
    .SYS_CLK    (clk),
    .RST        (rst),
    .DVALID_BAR (dv0),
    .DOUT       (do0),
    .DXMIT_BAR  (dx0),
    .host       (bus0.slave)
  );

  readout_multi #(.MSB_FIRST(1)) dut1 (
    .SYS_CLK    (clk),
    .RST        (rst),
    .DVALID_BAR (dv1),
    .DOUT       (do1),
    .DXMIT_BAR  (dx1),
    .host       (bus1.slave)
  );

  always @(negedge clk) if (bus0.done === 1'b1) done_cnt0++;

  function automatic logic [39:0] fdata(input int s);
    fdata = {20'(s * 7 + 3), 20'(s ^ 32'h000F0F0F)};
  endfunction

  function automatic logic [63:0] wrd(input int s);
    wrd = {8'(s), 16'h0, fdata(s)};
  endfunction

  task automatic send0(input logic [39:0] bits, input int glitch_at,
                       input int rst_at, output int lowcnt);
    int t;
    lowcnt = 0;
    dv0 = 1'b1;
    repeat (3) @(negedge clk);
    dv0 = 1'b0;
    t = 0;
    while (dx0 !== 1'b0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (dx0 !== 1'b0) begin
      n_bad++;
      $display("FAIL xmit_start0: DXMIT_BAR=%b want 0", dx0);
    end
    for (int k = 0; k < 40; k++) begin
      if (k == rst_at) begin
        rst = 1'b1;
        dv0 = 1'b1;
        #1;
        return;
      end
      if (dx0 === 1'b0) lowcnt++;
      if (k == glitch_at) dv0 = 1'b1;
      if (k == glitch_at + 4) dv0 = 1'b0;
      do0 = bits[k];
      @(negedge clk);
    end
    dv0 = 1'b1;
  endtask

  task automatic send1(input logic [19:0] ch0, input logic [19:0] ch1,
                       output int lowcnt);
    int t;
    logic [39:0] s;
    for (int k = 0; k < 20; k++) begin
      s[k]      = ch0[19-k];
      s[k + 20] = ch1[19-k];
    end
    lowcnt = 0;
    dv1 = 1'b1;
    repeat (3) @(negedge clk);
    dv1 = 1'b0;
    t = 0;
    while (dx1 !== 1'b0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (dx1 !== 1'b0) begin
      n_bad++;
      $display("FAIL xmit_start1: DXMIT_BAR=%b want 0", dx1);
    end
    for (int k = 0; k < 40; k++) begin
      if (dx1 === 1'b0) lowcnt++;
      do1 = s[k];
      @(negedge clk);
    end
    dv1 = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dv0 = 1'b1;
    dv1 = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (dx0 !== 1'b1) begin n_bad++; $display("FAIL rst_dxmit: got %b want 1", dx0); end
    n_cmp++; if (bus0.done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", bus0.done); end
    n_cmp++; if (bus0.state !== 2'd0) begin n_bad++; $display("FAIL rst_state: got %0d want 0", bus0.state); end
    n_cmp++; if (bus0.data2pipe !== 64'h0) begin n_bad++; $display("FAIL rst_data: got %h want 0", bus0.data2pipe); end
    n_cmp++; if (bus0.fifo_empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty: got %b want 1", bus0.fifo_empty); end
    n_cmp++; if (bus0.fifo_full !== 1'b0) begin n_bad++; $display("FAIL rst_full: got %b want 0", bus0.fifo_full); end
    n_cmp++; if (bus0.fifo_flag !== 1'b0) begin n_bad++; $display("FAIL rst_flag: got %b want 0", bus0.fifo_flag); end
    n_cmp++; if (bus0.fifo_level !== 7'd0) begin n_bad++; $display("FAIL rst_level: got %0d want 0", bus0.fifo_level); end
    n_cmp++; if (bus0.overflow_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_ovf: got %0d want 0", bus0.overflow_cnt); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lc, d;
    d = done_cnt0;
    send0({20'hABCDE, 20'h12345}, 100, -1, lc);
    n_cmp++; if (lc != 40) begin n_bad++; $display("FAIL basic_lowcnt: got %0d want 40", lc); end
    n_cmp++; if (dx0 !== 1'b1) begin n_bad++; $display("FAIL basic_dxmit_hi: got %b want 1", dx0); end
    n_cmp++; if (bus0.state !== 2'd2) begin n_bad++; $display("FAIL basic_push_state: got %0d want 2", bus0.state); end
    n_cmp++; if (bus0.done !== 1'b1) begin n_bad++; $display("FAIL basic_done: got %b want 1", bus0.done); end
    @(negedge clk);
    n_cmp++; if (bus0.data2pipe !== 64'h000000ABCDE12345) begin n_bad++; $display("FAIL basic_word: got %h want 000000abcde12345", bus0.data2pipe); end
    n_cmp++; if (bus0.fifo_level !== 7'd1) begin n_bad++; $display("FAIL basic_level: got %0d want 1", bus0.fifo_level); end
    n_cmp++; if (bus0.fifo_empty !== 1'b0) begin n_bad++; $display("FAIL basic_nonempty: got %b want 0", bus0.fifo_empty); end
    n_cmp++; if (done_cnt0 - d != 1) begin n_bad++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt0 - d); end
    bus0.fiforead = 1'b1;
    @(negedge clk);
    bus0.fiforead = 1'b0;
    n_cmp++; if (bus0.fifo_empty !== 1'b1) begin n_bad++; $display("FAIL basic_empty_after_pop: got %b want 1", bus0.fifo_empty); end
    n_cmp++; if (bus0.fifo_level !== 7'd0) begin n_bad++; $display("FAIL basic_level_after_pop: got %0d want 0", bus0.fifo_level); end
    n_cmp++; if (bus0.data2pipe !== 64'h000000ABCDE12345) begin n_bad++; $display("FAIL basic_hold: got %h want 000000abcde12345", bus0.data2pipe); end
  endtask

  task automatic test_msb_first();
    int lc;
    send1(20'h12345, 20'hABCDE, lc);
    n_cmp++; if (lc != 40) begin n_bad++; $display("FAIL msb_lowcnt: got %0d want 40", lc); end
    @(negedge clk);
    n_cmp++; if (bus1.data2pipe !== 64'h000000ABCDE12345) begin n_bad++; $display("FAIL msb_word: got %h want 000000abcde12345", bus1.data2pipe); end
  endtask

  task automatic test_fill_overflow();
    int lc, d;
    logic ef, eu;
    do_reset();
    for (int f = 0; f < 64; f++) begin
      send0(fdata(f), 100, -1, lc);
      @(negedge clk);
      ef = (f + 1 >= 32);
      eu = (f + 1 == 64);
      n_cmp++; if (bus0.fifo_level !== 7'(f + 1)) begin n_bad++; $display("FAIL fill_level: f=%0d got %0d want %0d", f, bus0.fifo_level, f + 1); end
      n_cmp++; if (bus0.fifo_flag !== ef) begin n_bad++; $display("FAIL fill_flag: f=%0d got %b want %b", f, bus0.fifo_flag, ef); end
      n_cmp++; if (bus0.fifo_full !== eu) begin n_bad++; $display("FAIL fill_full: f=%0d got %b want %b", f, bus0.fifo_full, eu); end
    end
    n_cmp++; if (bus0.data2pipe !== wrd(0)) begin n_bad++; $display("FAIL fill_head: got %h want %h", bus0.data2pipe, wrd(0)); end
    d = done_cnt0;
    send0(fdata(64), 100, -1, lc);
    @(negedge clk);
    n_cmp++; if (bus0.overflow_cnt !== 16'd1) begin n_bad++; $display("FAIL ovf_cnt: got %0d want 1", bus0.overflow_cnt); end
    n_cmp++; if (bus0.fifo_level !== 7'd64) begin n_bad++; $display("FAIL ovf_level: got %0d want 64", bus0.fifo_level); end
    n_cmp++; if (done_cnt0 - d != 1) begin n_bad++; $display("FAIL ovf_done: got %0d want 1", done_cnt0 - d); end
    n_cmp++; if (bus0.data2pipe !== wrd(0)) begin n_bad++; $display("FAIL ovf_head: got %h want %h", bus0.data2pipe, wrd(0)); end
    // Pop in the PUSH cycle while full.
    send0(fdata(8'h41), 100, -1, lc);
    bus0.fiforead = 1'b1;
    @(negedge clk);
    bus0.fiforead = 1'b0;
    n_cmp++; if (bus0.fifo_level !== 7'd64) begin n_bad++; $display("FAIL popfull_level: got %0d want 64", bus0.fifo_level); end
    n_cmp++; if (bus0.overflow_cnt !== 16'd1) begin n_bad++; $display("FAIL popfull_ovf: got %0d want 1", bus0.overflow_cnt); end
    n_cmp++; if (bus0.fifo_full !== 1'b1) begin n_bad++; $display("FAIL popfull_full: got %b want 1", bus0.fifo_full); end
    n_cmp++; if (bus0.data2pipe !== wrd(1)) begin n_bad++; $display("FAIL popfull_head: got %h want %h", bus0.data2pipe, wrd(1)); end
    bus0.fiforead = 1'b1;
    for (int i = 0; i < 64; i++) begin
      d = (i < 63) ? i + 1 : 8'h41;
      n_cmp++; if (bus0.data2pipe !== wrd(d)) begin n_bad++; $display("FAIL drain_word: i=%0d got %h want %h", i, bus0.data2pipe, wrd(d)); end
      @(negedge clk);
    end
    bus0.fiforead = 1'b0;
    n_cmp++; if (bus0.fifo_empty !== 1'b1) begin n_bad++; $display("FAIL drain_empty: got %b want 1", bus0.fifo_empty); end
    n_cmp++; if (bus0.fifo_level !== 7'd0) begin n_bad++; $display("FAIL drain_level: got %0d want 0", bus0.fifo_level); end
  endtask

  task automatic test_extra_pulse();
    int lc, d;
    send0(fdata(8'h42), 10, -1, lc);
    n_cmp++; if (lc != 40) begin n_bad++; $display("FAIL glitch_lowcnt: got %0d want 40", lc); end
    repeat (6) @(negedge clk);
    n_cmp++; if (bus0.fifo_level !== 7'd1) begin n_bad++; $display("FAIL glitch_level: got %0d want 1", bus0.fifo_level); end
    n_cmp++; if (bus0.state !== 2'd0) begin n_bad++; $display("FAIL glitch_idle: got %0d want 0", bus0.state); end
    n_cmp++; if (bus0.data2pipe !== wrd(8'h42)) begin n_bad++; $display("FAIL glitch_word: got %h want %h", bus0.data2pipe, wrd(8'h42)); end
    d = done_cnt0;
    send0(fdata(8'h43), 100, -1, lc);
    @(negedge clk);
    n_cmp++; if (bus0.fifo_level !== 7'd2) begin n_bad++; $display("FAIL glitch_next_level: got %0d want 2", bus0.fifo_level); end
    n_cmp++; if (done_cnt0 - d != 1) begin n_bad++; $display("FAIL glitch_next_done: got %0d want 1", done_cnt0 - d); end
    bus0.fiforead = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus0.data2pipe !== wrd(8'h43)) begin n_bad++; $display("FAIL glitch_next_word: got %h want %h", bus0.data2pipe, wrd(8'h43)); end
    @(negedge clk);
    bus0.fiforead = 1'b0;
    n_cmp++; if (bus0.fifo_empty !== 1'b1) begin n_bad++; $display("FAIL glitch_empty: got %b want 1", bus0.fifo_empty); end
  endtask

  task automatic test_reset_mid();
    int lc;
    send0(fdata(8'h44), 100, -1, lc);
    @(negedge clk);
    n_cmp++; if (bus0.fifo_level !== 7'd1) begin n_bad++; $display("FAIL rmid_pre_level: got %0d want 1", bus0.fifo_level); end
    send0(fdata(9), 100, 17, lc);
    n_cmp++; if (dx0 !== 1'b1) begin n_bad++; $display("FAIL rmid_dxmit: got %b want 1", dx0); end
    n_cmp++; if (bus0.fifo_level !== 7'd0) begin n_bad++; $display("FAIL rmid_level: got %0d want 0", bus0.fifo_level); end
    n_cmp++; if (bus0.state !== 2'd0) begin n_bad++; $display("FAIL rmid_state: got %0d want 0", bus0.state); end
    @(negedge clk);
    rst = 1'b0;
    repeat (45) @(negedge clk);
    n_cmp++; if (bus0.fifo_empty !== 1'b1) begin n_bad++; $display("FAIL rmid_nopush: got %b want 1", bus0.fifo_empty); end
    send0(fdata(5), 100, -1, lc);
    @(negedge clk);
    n_cmp++; if (bus0.data2pipe !== {8'h00, 16'h0, fdata(5)}) begin n_bad++; $display("FAIL rmid_seq0: got %h want %h", bus0.data2pipe, {8'h00, 16'h0, fdata(5)}); end
  endtask

  initial begin
    rst = 1'b1;
    dv0 = 1'b1;
    do0 = 1'b0;
    dv1 = 1'b1;
    do1 = 1'b0;
    bus0.fiforead = 1'b0;
    bus1.fiforead = 1'b0;
    test_reset();
    test_basic();
    test_msb_first();
    test_fill_overflow();
    test_extra_pulse();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
